// File: rtl/cp0_if.sv
// cp0_if: M-stage <-> coprocessor-0 signal bundle.
// The pipeline side drives the master modport; cp0 uses the slave modport.
interface cp0_if;
    logic        en;
    logic [4:0]  CP0Addr;
    logic [31:0] CP0In;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] CP0Out;
    logic [31:0] EPCOut;
    logic        Req;

    modport master (
        output en, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  CP0Out, EPCOut, Req
    );

    modport slave (
        input  en, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output CP0Out, EPCOut, Req
    );
endinterface

// File: rtl/cp0.sv
// cp0: coprocessor 0 for the P7 pipelined MIPS core (memory stage).
// Holds SR, Cause and EPC, decides exception/interrupt entry (Req) and
// serves mfc0/mtc0/eret. Optional Count/Compare timer is built when the
// macro CP0_TIMER_EN is defined; otherwise regs 9/11 read 0 and TI is 0.
module cp0 (
    input  logic  clk,
    input  logic  reset,
    cp0_if.slave  bus
);
    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_SR      = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    logic [5:0]  im_reg;
    logic        exl_reg;
    logic        ie_reg;
    logic        bd_reg;
    logic [5:0]  ip_reg;
    logic [4:0]  exc_code_reg;
    logic [31:0] epc_reg;
    logic        ti_reg;
    logic [31:0] count_reg;
    logic [31:0] compare_reg;

    logic [5:0]  int_vec;
    logic        int_req;
    logic        exc_req;
    logic        req;
    logic        mtc0_ok;
    logic [31:0] rd_data;

    // Effective interrupt vector: lines 0..4 straight from HWInt, line 5
    // also carries the timer interrupt.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_hw_line
            assign int_vec[gi] = bus.HWInt[gi];
        end
    endgenerate
    assign int_vec[5] = bus.HWInt[5] | ti_reg;

    // Interrupts outrank exceptions; nothing is taken while EXL is set or
    // while the core is held in reset.
    assign int_req = (|(int_vec & im_reg)) & ie_reg & ~exl_reg;
    assign exc_req = (bus.ExcCodeIn != 5'd0) & ~exl_reg;
    assign req     = (int_req | exc_req) & ~reset;
    assign bus.Req = req;

    // An mtc0 that coincides with exception entry is dropped entirely.
    assign mtc0_ok = bus.en & ~req;

    // SR, Cause and EPC state: exception entry beats eret, which beats mtc0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_reg       <= 6'd0;
            exl_reg      <= 1'b0;
            ie_reg       <= 1'b0;
            bd_reg       <= 1'b0;
            ip_reg       <= 6'd0;
            exc_code_reg <= 5'd0;
            epc_reg      <= 32'd0;
        end else begin
            ip_reg <= int_vec;
            if (req) begin
                exl_reg      <= 1'b1;
                bd_reg       <= bus.BDIn;
                exc_code_reg <= int_req ? 5'd0 : bus.ExcCodeIn;
                epc_reg      <= bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
            end else begin
                if (mtc0_ok && bus.CP0Addr == ADDR_SR) begin
                    im_reg  <= bus.CP0In[15:10];
                    ie_reg  <= bus.CP0In[0];
                    exl_reg <= bus.EXLClr ? 1'b0 : bus.CP0In[1];
                end else if (bus.EXLClr) begin
                    exl_reg <= 1'b0;
                end
                if (mtc0_ok && bus.CP0Addr == ADDR_EPC) begin
                    epc_reg <= bus.CP0In;
                end
            end
        end
    end

`ifdef CP0_TIMER_EN
    // Free-running Count with Compare match raising TI; writing Compare
    // acknowledges the timer interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg   <= 32'd0;
            compare_reg <= 32'd0;
            ti_reg      <= 1'b0;
        end else begin
            if (mtc0_ok && bus.CP0Addr == ADDR_COUNT) begin
                count_reg <= bus.CP0In;
            end else begin
                count_reg <= count_reg + 32'd1;
            end
            if (mtc0_ok && bus.CP0Addr == ADDR_COMPARE) begin
                compare_reg <= bus.CP0In;
                ti_reg      <= 1'b0;
            end else if (count_reg == compare_reg && compare_reg != 32'd0) begin
                ti_reg <= 1'b1;
            end
        end
    end
`else
    assign count_reg   = 32'd0;
    assign compare_reg = 32'd0;
    assign ti_reg      = 1'b0;
`endif

    // mfc0 read mux; unimplemented addresses read 0.
    always_comb begin
        rd_data = 32'd0;
        case (bus.CP0Addr)
            ADDR_SR:      rd_data = {16'd0, im_reg, 8'd0, exl_reg, ie_reg};
            ADDR_CAUSE:   rd_data = {bd_reg, ti_reg, 14'd0, ip_reg, 3'd0, exc_code_reg, 2'd0};
            ADDR_EPC:     rd_data = epc_reg;
            ADDR_COUNT:   rd_data = count_reg;
            ADDR_COMPARE: rd_data = compare_reg;
            default:      rd_data = 32'd0;
        endcase
    end

    assign bus.CP0Out = reset ? 32'd0 : rd_data;

    // Bypass lets an eret directly after mtc0 EPC return to the new target.
    assign bus.EPCOut = (bus.en && bus.CP0Addr == ADDR_EPC) ? bus.CP0In : epc_reg;
endmodule
